// File: rtl/npc_predict_pkg.sv
// Shared definitions for the fetch-PC predictor: counter encodings and
// helpers that derive BTB entry field widths from the top parameters.
package npc_predict_pkg;

   // 2-bit saturating direction counter; bit 1 is the taken prediction.
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   localparam int CTR_W = 2;

   // Number of PC bits used to index the BTB.
   function automatic int btb_idx_w(input int entries);
      return $clog2(entries);
   endfunction

   // Tag covers every PC bit above the index and the word offset.
   function automatic int btb_tag_w(input int xlen, input int entries);
      return xlen - $clog2(entries) - 2;
   endfunction

   // Saturating step toward the resolved direction.
   function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                  input logic taken);
      logic [CTR_W-1:0] res;
      res = ctr;
      if (taken && (ctr != CTR_ST)) res = ctr + 2'd1;
      if (!taken && (ctr != CTR_SNT)) res = ctr - 2'd1;
      return res;
   endfunction

endpackage

// File: rtl/npc_predict_if.sv
// Bundle between the fetch-PC unit, the IF stage and the EX stage.
// ex_valid qualifies all ex_* fields for exactly one cycle; there is no
// back-pressure on this path, so a stalled EX stage must drop ex_valid.
interface npc_predict_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic [XLEN-1:0] pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            ex_valid;
   logic            ex_is_br;
   logic            ex_is_jmp;
   logic [XLEN-1:0] ex_pc;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            flush;

   // Pipeline side: drives stall and EX resolution, consumes fetch PC.
   modport master (
      output stall, ex_valid, ex_is_br, ex_is_jmp, ex_pc, ex_taken,
             ex_target, ex_pred_taken, ex_pred_target,
      input  pc, pred_taken, pred_target, flush
   );

   // Fetch-PC unit side.
   modport slave (
      input  stall, ex_valid, ex_is_br, ex_is_jmp, ex_pc, ex_taken,
             ex_target, ex_pred_taken, ex_pred_target,
      output pc, pred_taken, pred_target, flush
   );
endinterface

// File: rtl/npc_predict_btb_table.sv
// Direct-mapped branch target buffer. Combinational read port on the fetch
// PC, one write port from EX resolution. A same-index read and write in one
// cycle returns the old contents because the write lands on the clock edge.
module npc_predict_btb_table
   import npc_predict_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         ENTRIES   = 16,
   parameter logic [1:0] ALLOC_CTR = 2'b10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [XLEN-1:0]  rd_pc_i,
   output logic             rd_hit_o,
   output logic [CTR_W-1:0] rd_ctr_o,
   output logic [XLEN-1:0]  rd_target_o,
   input  logic             wr_en_i,
   input  logic             wr_is_jmp_i,
   input  logic             wr_taken_i,
   input  logic [XLEN-1:0]  wr_pc_i,
   input  logic [XLEN-1:0]  wr_target_i
);
   localparam int IDX = btb_idx_w(ENTRIES);
   localparam int TAG = btb_tag_w(XLEN, ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG-1:0]     tag_q    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];

   logic [IDX-1:0] rd_idx, wr_idx;
   logic [TAG-1:0] rd_tag, wr_tag;
   logic           wr_hit;
   logic           unused_low_bits;

   assign rd_idx = rd_pc_i[IDX+1:2];
   assign rd_tag = rd_pc_i[XLEN-1:IDX+2];
   assign wr_idx = wr_pc_i[IDX+1:2];
   assign wr_tag = wr_pc_i[XLEN-1:IDX+2];
   assign unused_low_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

   assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_ctr_o    = ctr_q[rd_idx];
   assign rd_target_o = target_q[rd_idx];
   assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   // Train on a hit, allocate/replace on a taken miss; reset clears valid only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         if (wr_hit) begin
            if (wr_is_jmp_i) begin
               ctr_q[wr_idx]    <= CTR_ST;
               target_q[wr_idx] <= wr_target_i;
            end else begin
               ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken_i);
               if (wr_taken_i) target_q[wr_idx] <= wr_target_i;
            end
         end else if (wr_taken_i) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
            ctr_q[wr_idx]    <= wr_is_jmp_i ? CTR_ST : ALLOC_CTR;
         end
      end
   end
endmodule

// File: rtl/npc_predict.sv
// Fetch-PC register with BTB-based next-PC prediction and EX-stage
// misprediction recovery (redirect plus flush of IF/ID and ID/EX).
module npc_predict
   import npc_predict_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter logic [1:0]      ALLOC_CTR   = 2'b10
) (
   input  logic         clk,
   input  logic         rst,
   npc_predict_if.slave bus
);
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  pc_plus4, ex_next;
   logic             btb_hit;
   logic [CTR_W-1:0] btb_ctr;
   logic [XLEN-1:0]  btb_target;
   logic             pred_taken;
   logic             ex_ctl;
   logic             mispredict;
   logic             unused_pred_taken;

   npc_predict_btb_table #(
      .XLEN      (XLEN),
      .ENTRIES   (BTB_ENTRIES),
      .ALLOC_CTR (ALLOC_CTR)
   ) u_btb (
      .clk_i       (clk),
      .rst_i       (rst),
      .rd_pc_i     (pc_q),
      .rd_hit_o    (btb_hit),
      .rd_ctr_o    (btb_ctr),
      .rd_target_o (btb_target),
      .wr_en_i     (ex_ctl),
      .wr_is_jmp_i (bus.ex_is_jmp),
      .wr_taken_i  (bus.ex_taken),
      .wr_pc_i     (bus.ex_pc),
      .wr_target_i (bus.ex_target)
   );

   // The carried direction is implied by the carried target, so only the
   // target is compared; this also catches a stale JALR target.
   assign unused_pred_taken = bus.ex_pred_taken;

   assign pc_plus4   = pc_q + XLEN'(4);
   assign ex_next    = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
   assign ex_ctl     = bus.ex_valid && (bus.ex_is_br || bus.ex_is_jmp);
   assign mispredict = ex_ctl && (bus.ex_pred_target != ex_next);
   assign pred_taken = !rst && btb_hit && btb_ctr[1];

   assign bus.pc          = pc_q;
   assign bus.pred_taken  = pred_taken;
   assign bus.pred_target = pred_taken ? btb_target : pc_plus4;
   assign bus.flush       = !rst && mispredict;

   // Next PC: redirect beats stall, stall beats the predicted target.
   always_comb begin
      pc_d = bus.pred_target;
      if (bus.stall) pc_d = pc_q;
      if (mispredict) pc_d = ex_next;
   end

   // Fetch PC register.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end
endmodule

// File: tb/tb_npc_predict.sv
// Randomized and directed bench for npc_predict: a driver updates a
// behavioural model and queues the expected fetch outputs, a monitor pops
// and compares them half a cycle later.
module tb_npc_predict;
   localparam int W = 66;
   localparam int NENT = 16;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic clk;
   logic rst;

   npc_predict_if #(.XLEN(32)) bus ();

   npc_predict #(
      .XLEN        (32),
      .BTB_ENTRIES (NENT),
      .RESET_PC    (RESET_PC),
      .ALLOC_CTR   (2'b10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Reference model: word-addressed direct-mapped table.
   bit          m_valid [NENT];
   logic [31:0] m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   logic [31:0] m_pc;

   // ---------------- driver tasks ----------------
   task automatic step();
      int          i, j;
      bit          hit, pt, ctl, mis, h;
      logic [31:0] ptgt, nxt, t;
      i    = int'((m_pc >> 2) % NENT);
      hit  = m_valid[i] && (m_tag[i] == (m_pc >> 6));
      pt   = !rst && hit && (m_ctr[i] >= 2);
      ptgt = pt ? m_tgt[i] : m_pc + 32'd4;
      nxt  = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
      ctl  = bus.ex_valid && (bus.ex_is_br || bus.ex_is_jmp);
      mis  = ctl && (bus.ex_pred_target != nxt);
      exp_q.push_back({m_pc, pt, ptgt, (!rst && mis)});
      if (rst) begin
         m_pc = RESET_PC;
         for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
      end else begin
         if (mis)            m_pc = nxt;
         else if (!bus.stall) m_pc = ptgt;
         if (ctl) begin
            j = int'((bus.ex_pc >> 2) % NENT);
            t = bus.ex_pc >> 6;
            h = m_valid[j] && (m_tag[j] == t);
            if (h) begin
               if (bus.ex_is_jmp) begin
                  m_ctr[j] = 3;
                  m_tgt[j] = bus.ex_target;
               end else if (bus.ex_taken) begin
                  m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                  m_tgt[j] = bus.ex_target;
               end else begin
                  m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
               end
            end else if (bus.ex_taken) begin
               m_valid[j] = 1'b1;
               m_tag[j]   = t;
               m_tgt[j]   = bus.ex_target;
               m_ctr[j]   = bus.ex_is_jmp ? 3 : 2;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic v, input logic br,
                        input logic jmp, input logic [31:0] epc,
                        input logic tk, input logic [31:0] etgt,
                        input logic ept, input logic [31:0] eptgt);
      bus.stall          = st;
      bus.ex_valid       = v;
      bus.ex_is_br       = br;
      bus.ex_is_jmp      = jmp;
      bus.ex_pc          = epc;
      bus.ex_taken       = tk;
      bus.ex_target      = etgt;
      bus.ex_pred_taken  = ept;
      bus.ex_pred_target = eptgt;
      step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, '0, 0, '0, 0, '0);
   endtask

   // Not-taken branch at addr-4 carried with a wrong target: redirects to addr.
   task automatic redirect(input logic [31:0] addr);
      drive(0, 1, 1, 0, addr - 32'd4, 0, '0, 1, addr ^ 32'h100);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.pc, bus.pred_taken, bus.pred_target, bus.flush};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL fetch_outputs cycle %0d: got pc=%h pt=%b ptgt=%h flush=%b, want pc=%h pt=%b ptgt=%h flush=%b",
                        cyc, a[65:34], a[33], a[32:1], a[0],
                        e[65:34], e[33], e[32:1], e[0]);
            end
            cyc++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic        r_br, r_jmp, r_tk;
      logic [31:0] r_pc, r_tgt, r_nxt;
      int          wait_cnt;
      rst = 1'b1;
      bus.stall = 0; bus.ex_valid = 0; bus.ex_is_br = 0; bus.ex_is_jmp = 0;
      bus.ex_pc = '0; bus.ex_taken = 0; bus.ex_target = '0;
      bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
      m_pc = RESET_PC;
      for (int k = 0; k < NENT; k++) begin
         m_valid[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 0;
      end
      @(posedge clk);
      #1;

      // Reset held two cycles, then sequential fetch.
      idle(2);
      rst = 1'b0;
      idle(3);

      // Cold taken branch at 0x10 -> 0x40, then fetch 0x10 again.
      drive(0, 1, 1, 0, 32'h10, 1, 32'h40, 0, 32'h14);
      idle(1);
      redirect(32'h10);
      idle(2);

      // Three not-taken resolutions walk the counter down to 00.
      drive(0, 1, 1, 0, 32'h10, 0, '0, 1, 32'h40);
      drive(0, 1, 1, 0, 32'h10, 0, '0, 0, 32'h14);
      drive(0, 1, 1, 0, 32'h10, 0, '0, 0, 32'h14);
      redirect(32'h10);
      idle(2);

      // Stall holds the PC; a mispredict during stall still redirects.
      redirect(32'h20);
      drive(1, 0, 0, 0, '0, 0, '0, 0, '0);
      drive(1, 0, 0, 0, '0, 0, '0, 0, '0);
      drive(1, 1, 1, 0, 32'h30, 1, 32'h80, 0, 32'h34);
      drive(1, 0, 0, 0, '0, 0, '0, 0, '0);
      idle(2);

      // JALR with stale target, then an aliasing branch replaces the entry.
      drive(0, 1, 0, 1, 32'h10, 1, 32'h100, 0, 32'h14);
      redirect(32'h10);
      idle(1);
      drive(0, 1, 0, 1, 32'h10, 1, 32'h200, 1, 32'h100);
      redirect(32'h10);
      idle(1);
      drive(0, 1, 1, 0, 32'h50, 1, 32'h60, 0, 32'h54);
      redirect(32'h10);
      idle(1);
      redirect(32'h50);
      idle(1);

      // PC wraps from the top of the address space.
      redirect(32'hFFFF_FFFC);
      idle(2);

      // Reset arriving together with a mispredict wins.
      rst = 1'b1;
      drive(0, 1, 0, 1, 32'h30, 1, 32'h300, 0, 32'h34);
      rst = 1'b0;
      idle(3);
      redirect(32'h30);
      idle(1);

      // Randomized traffic over a small address window to force hits/aliases.
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 63) == 0);
         r_jmp = ($urandom_range(0, 3) == 0);
         r_br  = !r_jmp && ($urandom_range(0, 2) != 0);
         r_tk  = r_jmp ? 1'b1 : 1'($urandom_range(0, 1));
         r_pc  = 32'($urandom_range(0, 47)) * 32'd4;
         r_tgt = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                              : 32'($urandom_range(0, 47)) * 32'd4;
         r_nxt = r_tk ? r_tgt : r_pc + 32'd4;
         drive(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), r_br, r_jmp,
               r_pc, r_tk, r_tgt, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? r_nxt
                                           : 32'($urandom_range(0, 47)) * 32'd4);
      end
      rst = 1'b0;
      idle(2);

      // Drain: every queued expectation must have been consumed.
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
